// File: rtl/ram_bist.sv
// ram_bist: march-style built-in self-test initiator for a synchronous
// dual-port RAM. It runs four phases: write D(a) going up, read it back
// going up, write ~D(a) going down, then read that back going down. It
// records the first miscompare.
// Optional feature macro: RAM_BIST_STOP_ON_FAIL_EN. When it is defined, the
// test ends on the first miscompare.
module ram_bist #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] PATTERN      = DATA_WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // Compare pipeline depth: one stage for the registered read request,
  // plus one stage per cycle of RAM read latency.
  localparam int                    PIPE       = READ_LATENCY + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [2:0]            DRAIN_LAST = 3'(READ_LATENCY);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_UP  = 3'd1;
  localparam logic [2:0] S_RD_UP  = 3'd2;
  localparam logic [2:0] S_DRAIN1 = 3'd3;
  localparam logic [2:0] S_WR_DN  = 3'd4;
  localparam logic [2:0] S_RD_DN  = 3'd5;
  localparam logic [2:0] S_DRAIN2 = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [2:0]            drain_reg, drain_next;
  logic                  fail_flag_reg;
  logic                  accept, we_next, re_next, busy_next;
  logic                  cmp_hit, first_fail, abort;
  logic [DATA_WIDTH-1:0] pat_next;
  logic                  tail_valid;
  logic [ADDR_WIDTH-1:0] tail_addr;
  logic [DATA_WIDTH-1:0] tail_exp;

  // Test word for an address: the low address bits, zero-extended, XOR the seed.
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] ext;
    ext = '0;
    for (int i = 0; i < DATA_WIDTH && i < ADDR_WIDTH; i++) ext[i] = a[i];
    return ext ^ PATTERN;
  endfunction

  assign accept     = (state_reg == S_IDLE) && start;
  assign cmp_hit    = tail_valid && (ram_data_out != tail_exp);
  assign first_fail = cmp_hit && !fail_flag_reg;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
  assign abort = first_fail;
`else
  assign abort = 1'b0;
`endif

  // Next state and address counter. The downward phases reuse the same counter.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    drain_next = drain_reg;
    case (state_reg)
      S_IDLE:   if (start) begin state_next = S_WR_UP; addr_next = '0; end
      S_WR_UP:  if (addr_reg == ADDR_LAST) begin state_next = S_RD_UP; addr_next = '0; end
                else addr_next = addr_reg + 1'b1;
      S_RD_UP:  if (addr_reg == ADDR_LAST) begin state_next = S_DRAIN1; drain_next = '0; end
                else addr_next = addr_reg + 1'b1;
      S_DRAIN1: if (drain_reg == DRAIN_LAST) begin state_next = S_WR_DN; addr_next = ADDR_LAST; end
                else drain_next = drain_reg + 1'b1;
      S_WR_DN:  if (addr_reg == '0) begin state_next = S_RD_DN; addr_next = ADDR_LAST; end
                else addr_next = addr_reg - 1'b1;
      S_RD_DN:  if (addr_reg == '0) begin state_next = S_DRAIN2; drain_next = '0; end
                else addr_next = addr_reg - 1'b1;
      S_DRAIN2: if (drain_reg == DRAIN_LAST) state_next = S_FIN;
                else drain_next = drain_reg + 1'b1;
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (abort) state_next = S_FIN;
  end

  // Decode the RAM strobes from the next state so that every output comes straight from a flop.
  always_comb begin
    we_next   = (state_next == S_WR_UP) || (state_next == S_WR_DN);
    re_next   = (state_next == S_RD_UP) || (state_next == S_RD_DN);
    busy_next = (state_next != S_IDLE) && (state_next != S_FIN);
    pat_next  = pat(addr_next);
  end

  // Sequencer registers and the RAM port outputs. Idle address and data outputs are parked at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      drain_reg   <= '0;
      busy        <= 1'b0;
      ram_we      <= 1'b0;
      ram_re      <= 1'b0;
      ram_wr_addr <= '0;
      ram_rd_addr <= '0;
      ram_data_in <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      drain_reg   <= drain_next;
      busy        <= busy_next;
      ram_we      <= we_next;
      ram_re      <= re_next;
      ram_wr_addr <= we_next ? addr_next : '0;
      ram_rd_addr <= re_next ? addr_next : '0;
      ram_data_in <= !we_next ? '0 : (state_next == S_WR_DN) ? ~pat_next : pat_next;
    end
  end

  // Status: a start clears the result, the first miscompare is latched, and FIN publishes done/pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_flag_reg <= 1'b0;
      fail_addr     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
    end else if (accept) begin
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_flag_reg <= 1'b0;
      fail_addr     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
    end else begin
      if (first_fail) begin
        fail_flag_reg <= 1'b1;
        fail_addr     <= tail_addr;
        fail_data     <= ram_data_out;
        fail_expected <= tail_exp;
      end
      if (state_next == S_FIN) begin
        done <= 1'b1;
        pass <= !(fail_flag_reg || cmp_hit);
      end
    end
  end

  // Compare pipeline. Each read issue enters stage 0 alongside ram_re. The
  // entry reaches the last stage in the cycle its data is on ram_data_out.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE; gi++) begin : g_pipe
      logic                  valid_reg, valid_in;
      logic [ADDR_WIDTH-1:0] stage_addr_reg, addr_in;
      logic [DATA_WIDTH-1:0] exp_reg, exp_in;
      if (gi == 0) begin : g_head
        assign valid_in = re_next;
        assign addr_in  = addr_next;
        assign exp_in   = (state_next == S_RD_DN) ? ~pat_next : pat_next;
      end else begin : g_tail
        assign valid_in = g_pipe[gi-1].valid_reg;
        assign addr_in  = g_pipe[gi-1].stage_addr_reg;
        assign exp_in   = g_pipe[gi-1].exp_reg;
      end
      // One pipeline stage. An abort discards every in-flight entry.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg      <= 1'b0;
          stage_addr_reg <= '0;
          exp_reg        <= '0;
        end else begin
          valid_reg      <= valid_in && !abort;
          stage_addr_reg <= addr_in;
          exp_reg        <= exp_in;
        end
      end
    end
  endgenerate

  assign tail_valid = g_pipe[PIPE-1].valid_reg;
  assign tail_addr  = g_pipe[PIPE-1].stage_addr_reg;
  assign tail_exp   = g_pipe[PIPE-1].exp_reg;

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist (N=256, READ_LATENCY=1). It uses a RAM
// model with per-address stuck-at masks. It predicts the first miscompare by
// walking the march at a whole-array level.
module tb_ram_bist;
  localparam int N = 256;
  localparam int L = 1;
  localparam int RUN_CYCLES = 4 * N + 2 * (L + 1);

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, pass, ram_we, ram_re;
  logic [7:0] fail_addr, fail_data, fail_expected;
  logic [7:0] ram_wr_addr, ram_rd_addr, ram_data_in, ram_data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem   [N];
  logic [7:0] and_m [N];
  logic [7:0] or_m  [N];

  // Monitor counters only ever increase. Each run reads them as deltas from its base values.
  int busy_cnt = 0, we_cnt = 0, re_cnt = 0, overlap_cnt = 0, post_done_cnt = 0;
  int wr_seq_err = 0, rd_seq_err = 0;
  int wr_base = 0, rd_base = 0;
  logic [7:0] wr10 [2];

  ram_bist dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_expected(fail_expected),
    .ram_we(ram_we), .ram_re(ram_re), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dpat(input int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  // RAM model with one cycle of read latency. Stuck-at faults are applied on the read path.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_data_in;
    if (ram_re) ram_data_out <= (mem[ram_rd_addr] & and_m[ram_rd_addr]) | or_m[ram_rd_addr];
  end

  // Per-cycle observer. It compares the access streams with the march order: up D(a), then down ~D(a).
  always @(negedge clk) begin
    if (rst) begin
      int j, ea;
      if (busy) busy_cnt++;
      if (ram_we && ram_re) overlap_cnt++;
      if (done && (ram_we || ram_re)) post_done_cnt++;
      if (ram_we) begin
        j  = we_cnt - wr_base;
        ea = (j < N) ? j : 2 * N - 1 - j;
        if (j >= 2 * N || ram_wr_addr != 8'(ea) ||
            ram_data_in != ((j < N) ? dpat(ea) : ~dpat(ea))) wr_seq_err++;
        if (j < 2 * N && ram_wr_addr == 8'h10) wr10[(j < N) ? 0 : 1] = ram_data_in;
        we_cnt++;
      end
      if (ram_re) begin
        j  = re_cnt - rd_base;
        ea = (j < N) ? j : 2 * N - 1 - j;
        if (j >= 2 * N || ram_rd_addr != 8'(ea)) rd_seq_err++;
        re_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      and_m[i] = 8'hFF;
      or_m[i]  = 8'h00;
    end
  endtask

  // Walk both read phases in time order and return the first location that reads back wrong.
  task automatic predict(output logic ep, output logic [7:0] ea, output logic [7:0] ed,
                         output logic [7:0] ee);
    int a;
    logic [7:0] w, r;
    ep = 1'b1; ea = '0; ed = '0; ee = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < N; k++) begin
        a = (ph == 0) ? k : N - 1 - k;
        w = (ph == 0) ? dpat(a) : ~dpat(a);
        r = (w & and_m[a]) | or_m[a];
        if (ep && r != w) begin ep = 1'b0; ea = 8'(a); ed = r; ee = w; end
      end
    end
  endtask

  task automatic run_and_check(input string name);
    logic ep;
    logic [7:0] ea, ed, ee;
    int b0, w0, r0, ov0, pd0, ws0, rs0, cyc;
    predict(ep, ea, ed, ee);
    wr_base = we_cnt; rd_base = re_cnt;
    b0 = busy_cnt; w0 = we_cnt; r0 = re_cnt; ov0 = overlap_cnt; pd0 = post_done_cnt;
    ws0 = wr_seq_err; rs0 = rd_seq_err;
    wr10[0] = 8'h00; wr10[1] = 8'h00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3 * RUN_CYCLES) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_pass"}, 64'(pass), 64'(ep));
    check({name, "_fail_addr"}, 64'(fail_addr), 64'(ea));
    check({name, "_fail_data"}, 64'(fail_data), 64'(ed));
    check({name, "_fail_exp"}, 64'(fail_expected), 64'(ee));
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    if (ep) begin
`else
    begin
`endif
      check({name, "_busy_cycles"}, 64'(busy_cnt - b0), 64'(RUN_CYCLES));
      check({name, "_we_cycles"}, 64'(we_cnt - w0), 64'(2 * N));
      check({name, "_re_cycles"}, 64'(re_cnt - r0), 64'(2 * N));
      check({name, "_wr10_up"}, 64'(wr10[0]), 64'h0B5);
      check({name, "_wr10_dn"}, 64'(wr10[1]), 64'h04A);
    end
    check({name, "_wr_seq"}, 64'(wr_seq_err - ws0), 64'd0);
    check({name, "_rd_seq"}, 64'(rd_seq_err - rs0), 64'd0);
    repeat (3) @(negedge clk);
    check({name, "_done_hold"}, 64'({done, busy}), 64'b10);
    check({name, "_overlap"}, 64'(overlap_cnt - ov0), 64'd0);
    check({name, "_post_done"}, 64'(post_done_cnt - pd0), 64'd0);
    $display("run %s: pass=%0d fail_addr=%02h fail_data=%02h fail_expected=%02h", name,
             pass, fail_addr, fail_data, fail_expected);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, pass, fail_addr, fail_data, fail_expected, ram_we, ram_re,
                ram_wr_addr, ram_rd_addr, ram_data_in});
  endfunction

  initial begin
    int bad, nf, fa, fb;
    rst = 1'b0;
    start = 1'b0;
    clear_faults();

    // Reset held low while start toggles: every output must stay at zero.
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) start = ~start;
      if (all_outs() != 64'd0) bad++;
    end
    check("rst_outputs_zero", 64'(bad), 64'd0);
    @(negedge clk) begin start = 1'b0; rst = 1'b1; end
    repeat (5) @(negedge clk);
    check("idle_after_rst", 64'({busy, done, ram_we, ram_re}), 64'd0);

    // Clean run.
    run_and_check("clean");

    // Stuck-at-0 on bit 0 at 0x11. This location fails only in the descending read phase.
    clear_faults();
    and_m[8'h11] = 8'hFE;
    run_and_check("sa0_11");
    check("sa0_11_addr_const", 64'(fail_addr), 64'h11);
    check("sa0_11_data_const", 64'(fail_data), 64'h4A);
    check("sa0_11_exp_const", 64'(fail_expected), 64'h4B);

    // Two faults that fail in the ascending read phase. The earlier address is the one recorded.
    clear_faults();
    or_m[8'h05] = 8'h01;
    or_m[8'hF0] = 8'h02;
    run_and_check("multi");
    check("multi_addr_const", 64'(fail_addr), 64'h05);

    // Random fault sets.
    for (int r = 0; r < 5; r++) begin
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++) begin
        fa = $urandom_range(0, N - 1);
        fb = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) or_m[fa] = or_m[fa] | (8'h01 << fb);
        else and_m[fa] = and_m[fa] & ~(8'h01 << fb);
      end
      run_and_check($sformatf("rand%0d", r));
    end

    // Start pulsed mid-run is ignored. Reset asserted in the descending write phase aborts at once.
    clear_faults();
    wr_base = we_cnt; rd_base = re_cnt;
    fa = wr_seq_err;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (299) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (300) @(negedge clk);
    check("midrun_busy_we", 64'({busy, ram_we}), 64'b11);
    check("midrun_wr_seq", 64'(wr_seq_err - fa), 64'd0);
    #2 rst = 1'b0;
    #1 check("async_rst_outputs", all_outs(), 64'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_idle", 64'({busy, done, ram_we, ram_re}), 64'd0);
    run_and_check("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
